dffram_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port DFFRAM macro (CLK/WE0/EN0/A0/Di0/Do0) between two independent masters. Each master issues reads and byte-masked writes through a valid/ready request channel. Read data returns on a registered, non-backpressured response channel. Round-robin arbitration guarantees neither master starves. The block sits directly in front of the DFFRAM instance and is the only driver of its port.

---
 rtl/dffram_pkg.sv | 20 ++
 rtl/dffram_arbiter_rr_arbiter2.sv | 35 +++
 rtl/dffram_arbiter.sv | 119 +++++++++++
 tb/tb_dffram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dffram_pkg.sv
// Shared types for the DFFRAM front-end: requester IDs, read-pipeline tag
// and the address-width helper.
package dffram_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e owner;
    } rd_stage_t;

    // Sixteen words per bank.
    function automatic int awidth_f(input int banks);
        return $clog2(banks) + 4;
    endfunction

endpackage

// File: rtl/dffram_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. On a tie the requester that did not win last
// time is granted; last_grant powers up as B so A wins the first tie.
module rr_arbiter2
    import dffram_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] req_valid,
    output logic [1:0] gnt
);

    req_id_e last_grant;

    // NOTE: gnt gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        if (req_valid[0] && req_valid[1]) begin
            gnt = (last_grant == REQ_A) ? 2'b10 : 2'b01;
        end else begin
            gnt = req_valid;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_grant <= REQ_B;
        end else if (gnt[0]) begin
            last_grant <= REQ_A;
        end else if (gnt[1]) begin
            last_grant <= REQ_B;
        end
    end

endmodule

// File: rtl/dffram_arbiter.sv
// Shares one single-port DFFRAM between two masters: round-robin grant,
// port muxing, and a registered read-response path.
module dffram_arbiter
    import dffram_pkg::*;
#(
    parameter int WSIZE  = 4,
    parameter int BANKS  = 2,
    parameter int AWIDTH = awidth_f(BANKS)
) (
    input  logic                 CLK,
    input  logic                 RST_N,

    input  logic                 A_REQ_VALID,
    output logic                 A_REQ_READY,
    input  logic [WSIZE-1:0]     A_REQ_WE,
    input  logic [AWIDTH-1:0]    A_REQ_ADDR,
    input  logic [WSIZE*8-1:0]   A_REQ_DI,
    output logic                 A_RSP_VALID,
    output logic [WSIZE*8-1:0]   A_RSP_DO,

    input  logic                 B_REQ_VALID,
    output logic                 B_REQ_READY,
    input  logic [WSIZE-1:0]     B_REQ_WE,
    input  logic [AWIDTH-1:0]    B_REQ_ADDR,
    input  logic [WSIZE*8-1:0]   B_REQ_DI,
    output logic                 B_RSP_VALID,
    output logic [WSIZE*8-1:0]   B_RSP_DO,

    output logic [WSIZE-1:0]     WE0,
    output logic                 EN0,
    output logic [AWIDTH-1:0]    A0,
    output logic [WSIZE*8-1:0]   Di0,
    input  logic [WSIZE*8-1:0]   Do0
);

    localparam int DWIDTH = WSIZE * 8;

    logic [1:0]        gnt;
    logic              rd_fire;
    logic [AWIDTH-1:0] a0_hold;
    logic [DWIDTH-1:0] di0_hold;
    rd_stage_t         s1;
    rd_stage_t         s2;
    logic [DWIDTH-1:0] s2_data;

    rr_arbiter2 u_arb (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid ({B_REQ_VALID, A_REQ_VALID}),
        .gnt       (gnt)
    );

    assign A_REQ_READY = gnt[0];
    assign B_REQ_READY = gnt[1];
    assign EN0         = |gnt;

    // Address and write data park on the last granted value while idle.
    always_comb begin
        WE0 = '0;
        A0  = a0_hold;
        Di0 = di0_hold;
        if (gnt[0]) begin
            WE0 = A_REQ_WE;
            A0  = A_REQ_ADDR;
            Di0 = A_REQ_DI;
        end else if (gnt[1]) begin
            WE0 = B_REQ_WE;
            A0  = B_REQ_ADDR;
            Di0 = B_REQ_DI;
        end
    end

    assign rd_fire = EN0 && (WE0 == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a0_hold  <= '0;
            di0_hold <= '0;
        end else if (EN0) begin
            a0_hold  <= A0;
            di0_hold <= Di0;
        end
    end

    // s1 tags the read at the accepting edge; s2 captures Do0 while it is valid.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1      <= '0;
            s2      <= '0;
            s2_data <= '0;
        end else begin
            s1 <= '{valid: rd_fire, owner: (gnt[1] ? REQ_B : REQ_A)};
            s2 <= s1;
            if (s1.valid) begin
                s2_data <= Do0;
            end
        end
    end

    // Only the owner's data register loads; the other keeps its last response.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            A_RSP_VALID <= 1'b0;
            B_RSP_VALID <= 1'b0;
            A_RSP_DO    <= '0;
            B_RSP_DO    <= '0;
        end else begin
            A_RSP_VALID <= s2.valid && (s2.owner == REQ_A);
            B_RSP_VALID <= s2.valid && (s2.owner == REQ_B);
            if (s2.valid && (s2.owner == REQ_A)) begin
                A_RSP_DO <= s2_data;
            end
            if (s2.valid && (s2.owner == REQ_B)) begin
                B_RSP_DO <= s2_data;
            end
        end
    end

endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter with a behavioural DFFRAM model on the
// RAM port. Inputs change on the falling edge; outputs are sampled there too.
module tb_dffram_arbiter;

    localparam int WS = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          A_REQ_VALID, A_REQ_READY, A_RSP_VALID;
    logic [WS-1:0] A_REQ_WE;
    logic [AW-1:0] A_REQ_ADDR;
    logic [DW-1:0] A_REQ_DI, A_RSP_DO;
    logic          B_REQ_VALID, B_REQ_READY, B_RSP_VALID;
    logic [WS-1:0] B_REQ_WE;
    logic [AW-1:0] B_REQ_ADDR;
    logic [DW-1:0] B_REQ_DI, B_RSP_DO;
    logic [WS-1:0] WE0;
    logic          EN0;
    logic [AW-1:0] A0;
    logic [DW-1:0] Di0, Do0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    dffram_arbiter #(.WSIZE(WS), .BANKS(2)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_REQ_VALID(A_REQ_VALID), .A_REQ_READY(A_REQ_READY), .A_REQ_WE(A_REQ_WE),
        .A_REQ_ADDR(A_REQ_ADDR), .A_REQ_DI(A_REQ_DI), .A_RSP_VALID(A_RSP_VALID), .A_RSP_DO(A_RSP_DO),
        .B_REQ_VALID(B_REQ_VALID), .B_REQ_READY(B_REQ_READY), .B_REQ_WE(B_REQ_WE),
        .B_REQ_ADDR(B_REQ_ADDR), .B_REQ_DI(B_REQ_DI), .B_RSP_VALID(B_RSP_VALID), .B_RSP_DO(B_RSP_DO),
        .WE0(WE0), .EN0(EN0), .A0(A0), .Di0(Di0), .Do0(Do0)
    );

    // DFFRAM model: read data appears after the sampling edge, byte-masked writes.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (EN0) begin
            Do0 <= mem[A0];
            for (int b = 0; b < WS; b++) begin
                if (WE0[b]) mem[A0][8*b +: 8] <= Di0[8*b +: 8];
            end
        end
    end

    task automatic idle_inputs();
        A_REQ_VALID = 1'b0; A_REQ_WE = '0; A_REQ_ADDR = '0; A_REQ_DI = '0;
        B_REQ_VALID = 1'b0; B_REQ_WE = '0; B_REQ_ADDR = '0; B_REQ_DI = '0;
    endtask

    task automatic drive_a(input logic [WS-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] di);
        A_REQ_VALID = 1'b1; A_REQ_WE = we; A_REQ_ADDR = addr; A_REQ_DI = di;
    endtask

    task automatic drive_b(input logic [WS-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] di);
        B_REQ_VALID = 1'b1; B_REQ_WE = we; B_REQ_ADDR = addr; B_REQ_DI = di;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        idle_inputs();
        @(negedge CLK); #1;
        vectors++;
        if ({A_REQ_READY, B_REQ_READY, A_RSP_VALID, B_RSP_VALID, EN0} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000", {A_REQ_READY, B_REQ_READY, A_RSP_VALID, B_RSP_VALID, EN0});
        end
        vectors++;
        if ({WE0, A0, Di0} !== '0) begin
            miscompares++;
            $display("FAIL reset_ram_port: got WE0=%h A0=%h Di0=%h want all zero", WE0, A0, Di0);
        end
        vectors++;
        if ({A_RSP_DO, B_RSP_DO} !== '0) begin
            miscompares++;
            $display("FAIL reset_rsp_do: got A=%h B=%h want 0", A_RSP_DO, B_RSP_DO);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_single_master();
        logic [DW-1:0] wd [3] = '{32'hAA0055BB, 32'hAA0055CC, 32'hAA0055DD};
        for (int i = 0; i < 3; i++) begin
            drive_a(4'hF, AW'(i), wd[i]);
            #1;
            vectors++;
            if ({A_REQ_READY, B_REQ_READY, EN0, WE0, A0, Di0} !== {1'b1, 1'b0, 1'b1, 4'hF, AW'(i), wd[i]}) begin
                miscompares++;
                $display("FAIL single_wr%0d: got rdy=%b en=%b we=%h a=%h di=%h want rdy=1 en=1 we=f a=%h di=%h",
                         i, A_REQ_READY, EN0, WE0, A0, Di0, i, wd[i]);
            end
            @(negedge CLK);
        end
        drive_a(4'h0, 5'd0, 32'h0);
        #1;
        vectors++;
        if ({A_REQ_READY, WE0} !== {1'b1, 4'h0}) begin
            miscompares++;
            $display("FAIL single_rd_grant: got rdy=%b we=%h want rdy=1 we=0", A_REQ_READY, WE0);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (c == 0) A_REQ_VALID = 1'b0;
            vectors++;
            if ({A_RSP_VALID, B_RSP_VALID} !== {(c == 2), 1'b0}) begin
                miscompares++;
                $display("FAIL single_rd_valid c%0d: got A=%b B=%b want A=%b B=0", c, A_RSP_VALID, B_RSP_VALID, (c == 2));
            end
            if (c == 2) begin
                vectors++;
                if (A_RSP_DO !== 32'hAA0055BB) begin
                    miscompares++;
                    $display("FAIL single_rd_data: got %h want aa0055bb", A_RSP_DO);
                end
            end
        end
    endtask

    task automatic test_byte_masks();
        logic [WS-1:0] we  [3] = '{4'b0001, 4'b0010, 4'b0100};
        logic [AW-1:0] ad  [3] = '{5'd2, 5'd1, 5'd0};
        logic [DW-1:0] di  [3] = '{32'h00000033, 32'h00003300, 32'h00330000};
        logic [DW-1:0] exp [3] = '{32'hAA3355BB, 32'hAA0033CC, 32'hAA005533};
        for (int i = 0; i < 3; i++) begin
            drive_a(we[i], ad[i], di[i]);
            @(negedge CLK);
        end
        // Back-to-back reads of 0,1,2: one response per cycle, in order.
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive_a(4'h0, AW'(c), 32'h0);
            else       A_REQ_VALID = 1'b0;
            @(negedge CLK);
            vectors++;
            if ({A_RSP_VALID, B_RSP_VALID} !== {(c >= 2 && c < 5), 1'b0}) begin
                miscompares++;
                $display("FAIL mask_rd_valid c%0d: got A=%b B=%b want A=%b B=0", c, A_RSP_VALID, B_RSP_VALID, (c >= 2 && c < 5));
            end
            if (c >= 2 && c < 5) begin
                vectors++;
                if (A_RSP_DO !== exp[c-2]) begin
                    miscompares++;
                    $display("FAIL mask_rd_data @%0d: got %h want %h", c - 2, A_RSP_DO, exp[c-2]);
                end
            end
        end
    endtask

    task automatic test_contention();
        // A lone B read leaves last_grant = B, so the next tie goes to A.
        drive_b(4'h0, 5'd2, 32'h0);
        #1;
        vectors++;
        if ({A_REQ_READY, B_REQ_READY} !== 2'b01) begin
            miscompares++;
            $display("FAIL b_rd_grant: got A=%b B=%b want A=0 B=1", A_REQ_READY, B_REQ_READY);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (c == 0) B_REQ_VALID = 1'b0;
            vectors++;
            if ({A_RSP_VALID, B_RSP_VALID} !== {1'b0, (c == 2)}) begin
                miscompares++;
                $display("FAIL b_rd_valid c%0d: got A=%b B=%b want A=0 B=%b", c, A_RSP_VALID, B_RSP_VALID, (c == 2));
            end
            if (c == 2) begin
                vectors++;
                if (B_RSP_DO !== 32'hAA005533) begin
                    miscompares++;
                    $display("FAIL b_rd_data: got %h want aa005533", B_RSP_DO);
                end
            end
        end
        for (int c = 0; c < 9; c++) begin
            int r;
            if (c < 6) begin
                drive_a(4'h0, 5'd0, 32'h0);
                drive_b(4'h0, 5'd1, 32'h0);
                #1;
                vectors++;
                if ({A_REQ_READY, B_REQ_READY} !== {(c % 2 == 0), (c % 2 == 1)}) begin
                    miscompares++;
                    $display("FAIL tie_grant c%0d: got A=%b B=%b want A=%b B=%b",
                             c, A_REQ_READY, B_REQ_READY, (c % 2 == 0), (c % 2 == 1));
                end
            end else begin
                A_REQ_VALID = 1'b0;
                B_REQ_VALID = 1'b0;
            end
            @(negedge CLK);
            r = c - 2;
            vectors++;
            if ({A_RSP_VALID, B_RSP_VALID} !== {(r >= 0 && r < 6 && r % 2 == 0), (r >= 0 && r < 6 && r % 2 == 1)}) begin
                miscompares++;
                $display("FAIL tie_rsp_valid c%0d: got A=%b B=%b", c, A_RSP_VALID, B_RSP_VALID);
            end
            if (r >= 0 && r < 6) begin
                vectors++;
                if (r % 2 == 0 && A_RSP_DO !== 32'hAA3355BB) begin
                    miscompares++;
                    $display("FAIL tie_rsp_a r%0d: got %h want aa3355bb", r, A_RSP_DO);
                end else if (r % 2 == 1 && B_RSP_DO !== 32'hAA0033CC) begin
                    miscompares++;
                    $display("FAIL tie_rsp_b r%0d: got %h want aa0033cc", r, B_RSP_DO);
                end
            end
        end
    endtask

    task automatic test_write_then_read();
        drive_b(4'hF, 5'd5, 32'h12345678);
        #1;
        vectors++;
        if ({B_REQ_READY, WE0, A0} !== {1'b1, 4'hF, 5'd5}) begin
            miscompares++;
            $display("FAIL wtr_write: got rdy=%b we=%h a=%h want rdy=1 we=f a=05", B_REQ_READY, WE0, A0);
        end
        @(negedge CLK);
        B_REQ_VALID = 1'b0;
        drive_a(4'h0, 5'd5, 32'h0);
        @(negedge CLK);
        A_REQ_VALID = 1'b0;
        @(negedge CLK);
        vectors++;
        if (A_RSP_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL wtr_early: got A_RSP_VALID=%b want 0", A_RSP_VALID);
        end
        @(negedge CLK);
        vectors++;
        if ({A_RSP_VALID, A_RSP_DO} !== {1'b1, 32'h12345678}) begin
            miscompares++;
            $display("FAIL wtr_data: got v=%b d=%h want v=1 d=12345678", A_RSP_VALID, A_RSP_DO);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_read();
        drive_a(4'h0, 5'd0, 32'h0);
        @(negedge CLK);
        A_REQ_VALID = 1'b0;
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({A_REQ_READY, B_REQ_READY, EN0, WE0, A0, Di0, A_RSP_DO, B_RSP_DO} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got en=%b we=%h a=%h di=%h adat=%h bdat=%h want all zero",
                     EN0, WE0, A0, Di0, A_RSP_DO, B_RSP_DO);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (c == 2) RST_N = 1'b1;
            vectors++;
            if ({A_RSP_VALID, B_RSP_VALID} !== 2'b00) begin
                miscompares++;
                $display("FAIL rst_mid_rsp c%0d: got A=%b B=%b want 0 0", c, A_RSP_VALID, B_RSP_VALID);
            end
        end
        drive_a(4'h0, 5'd5, 32'h0);
        drive_b(4'h0, 5'd1, 32'h0);
        #1;
        vectors++;
        if ({A_REQ_READY, B_REQ_READY} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_first_tie: got A=%b B=%b want A=1 B=0", A_REQ_READY, B_REQ_READY);
        end
        @(negedge CLK);
        A_REQ_VALID = 1'b0;
        @(negedge CLK);
        B_REQ_VALID = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({A_RSP_VALID, A_RSP_DO} !== {1'b1, 32'h12345678}) begin
            miscompares++;
            $display("FAIL rst_ram_kept: got v=%b d=%h want v=1 d=12345678", A_RSP_VALID, A_RSP_DO);
        end
        @(negedge CLK);
        vectors++;
        if ({B_RSP_VALID, B_RSP_DO} !== {1'b1, 32'hAA0033CC}) begin
            miscompares++;
            $display("FAIL rst_b_follow: got v=%b d=%h want v=1 d=aa0033cc", B_RSP_VALID, B_RSP_DO);
        end
        @(negedge CLK);
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            vectors++;
            if ({EN0, WE0, A_REQ_READY, B_REQ_READY, A0} !== {1'b0, 4'h0, 1'b0, 1'b0, 5'd1}) begin
                miscompares++;
                $display("FAIL idle c%0d: got en=%b we=%h rdyA=%b rdyB=%b a0=%h want 0 0 0 0 a0=01",
                         c, EN0, WE0, A_REQ_READY, B_REQ_READY, A0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_byte_masks();
        test_contention();
        test_write_then_read();
        test_reset_mid_read();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
